// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bram_port_arbiter
//  Purpose  : Shares one single-port BRAM between NPORTS requestors. One
//             request is granted per cycle (round-robin or fixed priority).
//             The granted request is registered onto the BRAM port. Read
//             responses are steered back to the originating port after the
//             BRAM read latency.
//  Ports    : clk, rst            - clock, asynchronous active-high reset
//             req_valid/we/addr/din - packed per-port request inputs
//             req_ready           - per-port grant (one-hot or zero)
//             rsp_valid, rsp_dout - per-port read strobe, shared read data
//             out_addr/dout/wea/en, out_din - BRAM port
//             busy                - high while any read is in flight
//  Revision : 1.0 - initial release
// ============================================================================
module bram_port_arbiter #(
    parameter int WIDTH   = 3,
    parameter int ADDR_W  = 16,
    parameter int NPORTS  = 4,
    parameter int RD_LAT  = 1,
    parameter int RR_MODE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        req_valid,
    input  logic [NPORTS-1:0]        req_we,
    input  logic [NPORTS*ADDR_W-1:0] req_addr,
    input  logic [NPORTS*WIDTH-1:0]  req_din,
    output logic [NPORTS-1:0]        req_ready,
    output logic [NPORTS-1:0]        rsp_valid,
    output logic [WIDTH-1:0]         rsp_dout,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [WIDTH-1:0]         out_dout,
    output logic                     out_wea,
    output logic                     out_en,
    input  logic [WIDTH-1:0]         out_din,
    output logic                     busy
);

    localparam int c_PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    // Round-robin pointer: first port examined in the next search.
    logic [c_PW-1:0]   r_ptr;

    // Grant selection.
    logic [NPORTS-1:0] w_grant_oh;
    logic [c_PW-1:0]   w_grant_idx;
    logic              w_any;
    logic              w_accept;
    int                w_start;
    int                w_idx;

    // Registered BRAM port and response path.
    logic [ADDR_W-1:0] r_out_addr;
    logic [WIDTH-1:0]  r_out_dout;
    logic              r_out_wea;
    logic              r_out_en;
    logic [NPORTS-1:0] r_rsp_valid;
    logic [WIDTH-1:0]  r_rsp_dout;

    // Tag pipeline: stage 0 is loaded at acceptance, stage RD_LAT is the
    // one whose read data is on out_din at the next edge.
    logic              r_tag_rd   [0:RD_LAT];
    logic [c_PW-1:0]   r_tag_port [0:RD_LAT];
    logic              w_busy;

    // ------------------------------------------------------------------
    // Arbitration: scan NPORTS candidates starting at the pointer (or at
    // port 0 in fixed-priority mode), wrapping modulo NPORTS.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_oh  = '0;
        w_grant_idx = '0;
        w_any       = 1'b0;
        w_idx       = 0;
        w_start     = (RR_MODE != 0) ? int'(r_ptr) : 0;
        for (int i = 0; i < NPORTS; i++) begin
            w_idx = w_start + i;
            if (w_idx >= NPORTS) begin
                w_idx = w_idx - NPORTS;
            end
            if (!w_any && req_valid[w_idx]) begin
                w_any              = 1'b1;
                w_grant_idx        = w_idx[c_PW-1:0];
                w_grant_oh[w_idx]  = 1'b1;
            end
        end
    end

    // The grant is masked by reset so nothing is offered while rst is high.
    assign req_ready = rst ? '0 : w_grant_oh;
    assign w_accept  = w_any & ~rst;

    // ------------------------------------------------------------------
    // Pointer update: next search starts just after the granted port.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            if (w_grant_idx == c_PW'(NPORTS - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_grant_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // BRAM command register. Address/data hold when idle so the BRAM
    // inputs do not toggle needlessly.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_addr <= '0;
            r_out_dout <= '0;
            r_out_wea  <= 1'b0;
            r_out_en   <= 1'b0;
        end else if (w_accept) begin
            r_out_addr <= req_addr[int'(w_grant_idx)*ADDR_W +: ADDR_W];
            r_out_dout <= req_din[int'(w_grant_idx)*WIDTH +: WIDTH];
            r_out_wea  <= req_we[w_grant_idx];
            r_out_en   <= 1'b1;
        end else begin
            r_out_wea  <= 1'b0;
            r_out_en   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read tag pipeline. Writes enter as empty tags so they never produce
    // a response; order of responses follows order of acceptance.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s <= RD_LAT; s++) begin
                r_tag_rd[s]   <= 1'b0;
                r_tag_port[s] <= '0;
            end
        end else begin
            r_tag_rd[0]   <= w_accept & ~req_we[w_grant_idx];
            r_tag_port[0] <= w_grant_idx;
            for (int s = 1; s <= RD_LAT; s++) begin
                r_tag_rd[s]   <= r_tag_rd[s-1];
                r_tag_port[s] <= r_tag_port[s-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response register: captures BRAM read data for the oldest tag.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_dout  <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (r_tag_rd[RD_LAT]) begin
                r_rsp_valid[r_tag_port[RD_LAT]] <= 1'b1;
                r_rsp_dout                      <= out_din;
            end
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int s = 0; s <= RD_LAT; s++) begin
            w_busy = w_busy | r_tag_rd[s];
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_dout  = r_rsp_dout;
    assign out_addr  = r_out_addr;
    assign out_dout  = r_out_dout;
    assign out_wea   = r_out_wea;
    assign out_en    = r_out_en;
    assign busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bram_port_arbiter
//  Purpose  : Directed self-checking bench for bram_port_arbiter with a
//             one-cycle-latency BRAM model. A second instance in fixed
//             priority mode shares the request inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

    localparam int W = 3;
    localparam int A = 16;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_we;
    logic [N*A-1:0] req_addr;
    logic [N*W-1:0] req_din;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_dout;
    logic [A-1:0]   out_addr;
    logic [W-1:0]   out_dout;
    logic           out_wea;
    logic           out_en;
    logic [W-1:0]   out_din;
    logic           busy;

    logic [N-1:0]   fp_req_ready;
    logic [N-1:0]   fp_rsp_valid;
    logic [W-1:0]   fp_rsp_dout;
    logic [A-1:0]   fp_out_addr;
    logic [W-1:0]   fp_out_dout;
    logic           fp_out_wea;
    logic           fp_out_en;
    logic           fp_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(.WIDTH(W), .ADDR_W(A), .NPORTS(N), .RD_LAT(1), .RR_MODE(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_din(req_din), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_dout(rsp_dout), .out_addr(out_addr),
        .out_dout(out_dout), .out_wea(out_wea), .out_en(out_en),
        .out_din(out_din), .busy(busy)
    );

    bram_port_arbiter #(.WIDTH(W), .ADDR_W(A), .NPORTS(N), .RD_LAT(1), .RR_MODE(0)) dut_fp (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_din(req_din), .req_ready(fp_req_ready),
        .rsp_valid(fp_rsp_valid), .rsp_dout(fp_rsp_dout), .out_addr(fp_out_addr),
        .out_dout(fp_out_dout), .out_wea(fp_out_wea), .out_en(fp_out_en),
        .out_din(3'd0), .busy(fp_busy)
    );

    // BRAM model, read latency 1. Contents are preset to addr[2:0] during reset.
    logic [W-1:0] mem [0:255];
    logic [W-1:0] bram_q;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= W'(i);
        end else if (out_en) begin
            if (out_wea) mem[out_addr[7:0]] <= out_dout;
            else         bram_q <= mem[out_addr[7:0]];
        end
    end
    assign out_din = bram_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_din   = '0;
    endtask

    task automatic set_req(input int p, input logic we, input logic [A-1:0] a, input logic [W-1:0] d);
        req_valid[p]       = 1'b1;
        req_we[p]          = we;
        req_addr[p*A +: A] = a;
        req_din[p*W +: W]  = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},   32'(req_ready), 32'h0);
        chk({tag, "_rspv"},    32'(rsp_valid), 32'h0);
        chk({tag, "_rspd"},    32'(rsp_dout),  32'h0);
        chk({tag, "_addr"},    32'(out_addr),  32'h0);
        chk({tag, "_dout"},    32'(out_dout),  32'h0);
        chk({tag, "_wea"},     32'(out_wea),   32'h0);
        chk({tag, "_en"},      32'(out_en),    32'h0);
        chk({tag, "_busy"},    32'(busy),      32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, with requests pending to show the grant is masked.
        rst = 1'b1;
        clear_req();
        req_valid = 4'hF;
        #2;
        chk_all_zero("reset");
        chk("reset_fp_ready", 32'(fp_req_ready), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        clear_req();

        // Port 2 writes 5 to 0x0010, then reads it back-to-back.
        set_req(2, 1'b1, 16'h0010, 3'd5);
        #1 chk("wr_ready", 32'(req_ready), 32'h4);
        tick();
        chk("wr_en",   32'(out_en),   32'h1);
        chk("wr_wea",  32'(out_wea),  32'h1);
        chk("wr_addr", 32'(out_addr), 32'h10);
        chk("wr_dout", 32'(out_dout), 32'h5);
        set_req(2, 1'b0, 16'h0010, 3'd0);
        #1 chk("rd_ready", 32'(req_ready), 32'h4);
        tick();
        chk("rd_en",   32'(out_en),  32'h1);
        chk("rd_wea",  32'(out_wea), 32'h0);
        chk("rd_busy", 32'(busy),    32'h1);
        clear_req();
        tick();
        chk("rd_idle_en",  32'(out_en),    32'h0);
        chk("wr_no_rsp",   32'(rsp_valid), 32'h0);
        tick();
        chk("rd_rspv", 32'(rsp_valid), 32'h4);
        chk("rd_rspd", 32'(rsp_dout),  32'h5);
        tick();
        chk("rd_rspv_off", 32'(rsp_valid), 32'h0);
        chk("rd_rspd_hold", 32'(rsp_dout), 32'h5);
        chk("rd_busy_off", 32'(busy),      32'h0);

        // Pointer wrap: port 3 alone, then ports 0 and 3 together.
        set_req(3, 1'b0, 16'h0003, 3'd0);
        #1 chk("wrap_p3", 32'(req_ready), 32'h8);
        tick();
        clear_req();
        set_req(0, 1'b0, 16'h0000, 3'd0);
        set_req(3, 1'b0, 16'h0003, 3'd0);
        #1 chk("wrap_p0", 32'(req_ready), 32'h1);
        tick();
        clear_req();
        tick();
        tick();
        tick();

        // Reset mid-operation: two reads accepted, then reset.
        set_req(1, 1'b0, 16'h0021, 3'd0);
        #1 chk("rst_mid_g1", 32'(req_ready), 32'h2);
        tick();
        clear_req();
        set_req(2, 1'b0, 16'h0022, 3'd0);
        #1;
        tick();
        chk("rst_mid_busy_pre", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        tick();
        tick();
        rst = 1'b0;
        clear_req();

        // Round-robin fairness: all four ports read continuously. Pointer
        // was cleared by reset, so port 0 wins first; acceptance is possible
        // at the first edge after release.
        for (int p = 0; p < N; p++) set_req(p, 1'b0, 16'(32'h20 + p), 3'd0);
        for (int i = 0; i < 8; i++) begin
            #1 chk($sformatf("rr_ready_%0d", i), 32'(req_ready), 32'(1 << (i % 4)));
            tick();
            chk($sformatf("rr_addr_%0d", i), 32'(out_addr), 32'h20 + 32'(i % 4));
            if (i >= 2) begin
                chk($sformatf("rr_rspv_%0d", i), 32'(rsp_valid), 32'(1 << ((i - 2) % 4)));
                chk($sformatf("rr_rspd_%0d", i), 32'(rsp_dout),  32'((i - 2) % 4));
            end else begin
                chk($sformatf("rr_rspv_%0d", i), 32'(rsp_valid), 32'h0);
            end
        end
        clear_req();
        tick();
        chk("rr_tail_v6", 32'(rsp_valid), 32'h4);
        chk("rr_tail_d6", 32'(rsp_dout),  32'h2);
        tick();
        chk("rr_tail_v7", 32'(rsp_valid), 32'h8);
        chk("rr_tail_d7", 32'(rsp_dout),  32'h3);

        // Fixed priority vs round robin with ports 1 and 3 held.
        set_req(1, 1'b0, 16'h0041, 3'd0);
        set_req(3, 1'b0, 16'h0043, 3'd0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("fp_ready_%0d", i), 32'(fp_req_ready), 32'h2);
            chk($sformatf("rr13_ready_%0d", i), 32'(req_ready), (i % 2 == 0) ? 32'h2 : 32'h8);
            tick();
        end
        clear_req();
        tick();
        tick();
        tick();

        // Idle hold after a read of 0x1234 (model returns 0x34 & 7 = 4).
        set_req(0, 1'b0, 16'h1234, 3'd0);
        #1;
        tick();
        chk("idle_acc_en",   32'(out_en),   32'h1);
        chk("idle_acc_addr", 32'(out_addr), 32'h1234);
        clear_req();
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("idle_en_%0d", c),   32'(out_en),   32'h0);
            chk($sformatf("idle_wea_%0d", c),  32'(out_wea),  32'h0);
            chk($sformatf("idle_addr_%0d", c), 32'(out_addr), 32'h1234);
            if (c == 1) chk("idle_rspv", 32'(rsp_valid), 32'h1);
            else        chk($sformatf("idle_rspv_%0d", c), 32'(rsp_valid), 32'h0);
            if (c >= 1) chk($sformatf("idle_rspd_%0d", c), 32'(rsp_dout), 32'h4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, the data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 16, the BRAM address width in bits.
REQ-003 The block SHALL have parameter NPORTS, default 4, the number of requestor ports; legal range is 2..8.
REQ-004 The block SHALL have parameter RD_LAT, default 1, the BRAM read latency in cycles; legal range is 1..3.
REQ-005 The block SHALL have parameter RR_MODE, default 1, the arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).
REQ-006 Port clk, input, 1 bit: the single clock, shared by the block and the BRAM.
REQ-007 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 Port req_valid, input, NPORTS bits: per-port request valid.
REQ-009 Port req_we, input, NPORTS bits: per-port write enable (1 = write, 0 = read).
REQ-010 Port req_addr, input, NPORTS*ADDR_W bits: packed per-port addresses; port p occupies slice [p*ADDR_W +: ADDR_W].
REQ-011 Port req_din, input, NPORTS*WIDTH bits: packed per-port write data, packed the same way.
REQ-012 Port req_ready, output, NPORTS bits: per-port grant; it is one-hot or zero.
REQ-013 Port rsp_valid, output, NPORTS bits: per-port read-response strobe.
REQ-014 Port rsp_dout, output, WIDTH bits: read data, shared by all ports.
REQ-015 Port out_addr, output, ADDR_W bits: BRAM address.
REQ-016 Port out_dout, output, WIDTH bits: BRAM write data.
REQ-017 Port out_wea, output, 1 bit: BRAM write enable.
REQ-018 Port out_en, output, 1 bit: BRAM enable.
REQ-019 Port out_din, input, WIDTH bits: BRAM read data.
REQ-020 Port busy, output, 1 bit: high while any read is in flight.

Function
REQ-021 req_ready SHALL be combinational from req_valid and the priority pointer, and SHALL select exactly one valid port whenever any req_valid bit is high.
REQ-022 A transaction on port p SHALL be accepted at the rising edge where req_valid[p] and req_ready[p] are both high.
REQ-023 The block SHALL accept at most one transaction per cycle and SHALL sustain one acceptance every cycle (no bubbles).
REQ-024 After acceptance at edge k, out_en SHALL be 1 for exactly the cycle following edge k, with registered out_addr, out_dout and out_wea.
  - out_addr and out_dout take the accepted port's slices.
  - out_wea = req_we[p].
REQ-025 In cycles with no acceptance, out_en and out_wea SHALL be 0, and out_addr and out_dout SHALL hold their last values.
REQ-026 For an accepted read from port p at edge k:
  - rsp_valid[p] SHALL be high for exactly the one cycle following edge k+RD_LAT+1.
  - rsp_dout SHALL be out_din registered at that edge.
REQ-027 Accepted writes SHALL NOT produce any rsp_valid.
REQ-028 rsp_dout SHALL hold its last value while no rsp_valid bit is high.
REQ-029 Read response tracking SHALL use a tag shift register RD_LAT+1 stages deep; each stage holds {read flag, port index}.
  - At most one rsp_valid bit is high per cycle.
  - Responses return in acceptance order.
REQ-030 RR_MODE=1: the search SHALL start at the pointer and wrap modulo NPORTS.
  - After each acceptance, the pointer SHALL become (granted index + 1) mod NPORTS; index NPORTS-1 wraps to 0.
  - The pointer SHALL be unchanged in cycles with no acceptance.
REQ-031 RR_MODE=0: the lowest-index valid port SHALL win, and the pointer SHALL be unused.
REQ-032 A port that deasserts req_valid before being granted SHALL lose its request without side effects.
REQ-033 A request SHALL be accepted only while rst is low.
REQ-034 busy SHALL be high whenever any tag stage holds a read flag.

Reset
REQ-035 While rst is high, the following outputs SHALL be 0 asynchronously: req_ready, rsp_valid, rsp_dout, out_addr, out_dout, out_wea, out_en, busy.
REQ-036 While rst is high, the round-robin pointer and all tag stages SHALL be cleared asynchronously.
REQ-037 In-flight reads at reset SHALL be discarded: no rsp_valid is issued for them after rst deasserts.
REQ-038 The first acceptance SHALL be possible at the first rising edge after rst deasserts.

Verification (NPORTS=4, WIDTH=3, RD_LAT=1, RR_MODE=1)
REQ-039 Single write then read:
  - Stimulus: port 2 writes addr 0x0010 data 5; port 2 then reads 0x0010 back-to-back.
  - Response: out_en high 2 consecutive cycles, the first with out_wea=1.
  - Response: rsp_valid[2]=1 with rsp_dout=5, exactly 2 cycles after the read acceptance.
REQ-040 Round-robin fairness:
  - Stimulus: all 4 ports hold req_valid=1 with reads for 8 cycles.
  - Response: grant order 0,1,2,3,0,1,2,3, with rsp_valid following the same order, each delayed 2 cycles.
REQ-041 Fixed priority:
  - Stimulus: RR_MODE=0; ports 1 and 3 hold req_valid=1 continuously.
  - Response: port 1 is granted every cycle and port 3 is never granted.
REQ-042 Pointer wrap:
  - Stimulus: port 3 is granted, then ports 0 and 3 request together.
  - Response: port 0 is granted first.
REQ-043 Reset mid-operation:
  - Stimulus: reads are accepted on 2 consecutive cycles, then rst is pulsed high one cycle later.
  - Response: all outputs are 0 immediately; no rsp_valid appears after release; busy=0.
REQ-044 Idle hold:
  - Stimulus: after a read of 0x1234, there are no requests for 5 cycles.
  - Response: out_en=0, out_wea=0, out_addr stays 0x1234, and rsp_dout holds its value.
